traffic_light_nway: RTL and testbench

TRAFFIC_LIGHT_NWAY -- requirements
Module: traffic_light_nway

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/phase_timer.sv | 62 ++++++
 rtl/traffic_light_nway.sv | 152 +++++++++++++++
 tb/tb_traffic_light_nway.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the N-way traffic light controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: controller state enum, per-way light triples {red, yellow, green},
// and a helper that advances the round-robin way index.
package traffic_pkg;

    // Encoding is visible on the phase output, so values are pinned explicitly.
    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } state_e;

    // Per-way light triple, bit order {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Round-robin successor of a way index for a controller serving n_way ways.
    function automatic logic [2:0] next_way(input logic [2:0] way, input int n_way);
        logic [2:0] last;
        last = 3'(n_way - 1);
        return (way == last) ? 3'd0 : way + 3'd1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick prescaler plus loadable phase down-counter for the traffic controller.
// Latency: tick_o is combinational from the registered prescaler; remaining_o is registered.
// Backpressure: none; free-running, load_i always wins over counting.
//
// Ports:
//   clk_i, rst_i      clock and asynchronous active-high reset
//   load_i            restart the phase: prescaler to 0, counter to load_val_i
//   load_val_i        phase duration minus one
//   tick_o            high for one cycle when the prescaler sits at TICK_DIV-1
//   expire_o          counter has reached zero (phase ends on the next tick)
//   remaining_o       current counter value
module phase_timer #(
    parameter int               TICK_DIV = 50000000,
    parameter int               CNT_W    = 8,
    parameter logic [CNT_W-1:0] RST_VAL  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tick_o,
    output logic             expire_o,
    output logic [CNT_W-1:0] remaining_o
);

    // A divide-by-one prescaler still needs one bit; it simply never leaves 0.
    localparam int              PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0]  ps_q,  ps_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    always_comb begin
        tick_o   = (ps_q == PS_MAX);
        expire_o = (rem_q == '0);

        ps_d = tick_o ? '0 : ps_q + 1'b1;
        if (load_i) begin
            ps_d = '0;
        end

        rem_d = rem_q;
        if (load_i) begin
            rem_d = load_val_i;
        end else if (tick_o && !expire_o) begin
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_q  <= '0;
            rem_q <= RST_VAL;
        end else begin
            ps_q  <= ps_d;
            rem_q <= rem_d;
        end
    end

    assign remaining_o = rem_q;

endmodule

// File: rtl/traffic_light_nway.sv
// Round-robin N-way traffic light controller with night-time flashing yellow.
// Latency: all outputs registered; they change one clk after the deciding tick.
// Backpressure: none; night_mode is a level request honoured at phase boundaries.
//
// Ports:
//   clk         single rising-edge clock
//   rst_n       asynchronous reset, active HIGH despite the name
//   night_mode  request flashing-yellow operation (sampled at end of all-red)
//   lights      per-way {red, yellow, green} at [3k+2:3k]
//   active_way  way owning green/yellow, or the next way during all-red
//   remaining   ticks left in the current phase minus one
//   phase       current state encoding (ALL_RED/GREEN/YELLOW/FLASH)
module traffic_light_nway
    import traffic_pkg::*;
#(
    parameter int N_WAY    = 2,
    parameter int TICK_DIV = 50000000,
    parameter int G_TIME   = 30,
    parameter int Y_TIME   = 3,
    parameter int AR_TIME  = 2,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               night_mode,
    output logic [3*N_WAY-1:0] lights,
    output logic [2:0]         active_way,
    output logic [CNT_W-1:0]   remaining,
    output logic [1:0]         phase
);

    localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(G_TIME - 1);
    localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(AR_TIME - 1);

    state_e             state_q, state_d;
    logic [2:0]         way_q,   way_d;
    logic               flash_q, flash_d;
    logic [3*N_WAY-1:0] lights_q, lights_d;

    logic               tick;
    logic               expire;
    logic               load;
    logic [CNT_W-1:0]   load_val;

    phase_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W),
        .RST_VAL  (AR_LOAD)
    ) u_timer (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .load_i      (load),
        .load_val_i  (load_val),
        .tick_o      (tick),
        .expire_o    (expire),
        .remaining_o (remaining)
    );

    // Next-state logic. Every transition happens on a tick; timed phases
    // additionally wait for the counter to expire. FLASH has no duration of
    // its own: it reloads zero each tick so it re-evaluates night_mode every tick.
    always_comb begin
        state_d  = state_q;
        way_d    = way_q;
        flash_d  = flash_q;
        load     = 1'b0;
        load_val = '0;

        if (tick) begin
            unique case (state_q)
                ALL_RED: begin
                    if (expire) begin
                        load = 1'b1;
                        if (night_mode) begin
                            state_d  = FLASH;
                            load_val = '0;
                            flash_d  = 1'b1;
                        end else begin
                            state_d  = GREEN;
                            load_val = G_LOAD;
                        end
                    end
                end
                GREEN: begin
                    if (expire) begin
                        state_d  = YELLOW;
                        load     = 1'b1;
                        load_val = Y_LOAD;
                    end
                end
                YELLOW: begin
                    if (expire) begin
                        state_d  = ALL_RED;
                        way_d    = next_way(way_q, N_WAY);
                        load     = 1'b1;
                        load_val = AR_LOAD;
                    end
                end
                FLASH: begin
                    load = 1'b1;
                    if (!night_mode) begin
                        // Leaving night operation always resumes from way 0.
                        state_d  = ALL_RED;
                        way_d    = 3'd0;
                        load_val = AR_LOAD;
                    end else begin
                        load_val = '0;
                        flash_d  = ~flash_q;
                    end
                end
                default: begin
                    state_d = ALL_RED;
                end
            endcase
        end
    end

    // Lights are decoded from the next state so the registered copy lines up
    // with phase/active_way on the same edge.
    always_comb begin
        lights_d = '0;
        for (int k = 0; k < N_WAY; k++) begin
            lights_d[3*k +: 3] = RED;
            unique case (state_d)
                GREEN:   if (way_d == 3'(k)) lights_d[3*k +: 3] = GRN;
                YELLOW:  if (way_d == 3'(k)) lights_d[3*k +: 3] = YEL;
                FLASH:   lights_d[3*k +: 3] = flash_d ? YEL : OFF;
                default: lights_d[3*k +: 3] = RED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ALL_RED;
            way_q    <= 3'd0;
            flash_q  <= 1'b0;
            lights_q <= {N_WAY{RED}};
        end else begin
            state_q  <= state_d;
            way_q    <= way_d;
            flash_q  <= flash_d;
            lights_q <= lights_d;
        end
    end

    assign lights     = lights_q;
    assign active_way = way_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_light_nway.sv
// Directed self-checking bench for traffic_light_nway (3 ways, tick every 4 clk).
// Timeline is tracked as rising edges counted since the last reset release.
module tb_traffic_light_nway;

    localparam int N_WAY    = 3;
    localparam int TICK_DIV = 4;
    localparam int G_TIME   = 5;
    localparam int Y_TIME   = 2;
    localparam int AR_TIME  = 1;
    localparam int CNT_W    = 8;

    localparam logic [8:0] L_ALLRED = 9'b100_100_100;
    localparam logic [8:0] L_G0     = 9'b100_100_001;
    localparam logic [8:0] L_Y0     = 9'b100_100_010;
    localparam logic [8:0] L_G1     = 9'b100_001_100;
    localparam logic [8:0] L_G2     = 9'b001_100_100;
    localparam logic [8:0] L_FLON   = 9'b010_010_010;
    localparam logic [8:0] L_FLOFF  = 9'b000_000_000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             night_mode;
    logic [8:0]       lights;
    logic [2:0]       active_way;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       phase;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always #5 clk = ~clk;

    traffic_light_nway #(
        .N_WAY    (N_WAY),
        .TICK_DIV (TICK_DIV),
        .G_TIME   (G_TIME),
        .Y_TIME   (Y_TIME),
        .AR_TIME  (AR_TIME),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .night_mode (night_mode),
        .lights     (lights),
        .active_way (active_way),
        .remaining  (remaining),
        .phase      (phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edges, obs, exp);
        end
    endtask

    // Advance to rising edge t (counted from reset release), sample on the falling edge.
    task automatic adv_to(input int t);
        while (edges < t) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] ph,
                             input logic [2:0] way, input logic [8:0] lt);
        chk({tag, ".phase"},  32'(phase),      32'(ph));
        chk({tag, ".way"},    32'(active_way), 32'(way));
        chk({tag, ".lights"}, 32'(lights),     32'(lt));
    endtask

    // Outside FLASH at most one way may be non-red.
    always @(negedge clk) begin
        int nonred;
        nonred = 0;
        for (int k = 0; k < N_WAY; k++) begin
            if (lights[3*k +: 3] != 3'b100) nonred++;
        end
        if (phase != 2'd3) begin
            checks++;
            assert (nonred <= 1) else begin
                errors++;
                $error("FAIL exclusive: observed %0d non-red ways expected at most 1", nonred);
            end
        end
    end

    initial begin
        rst_n      = 1'b1;
        night_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values while held.
        chk_state("rst", 2'd0, 3'd0, L_ALLRED);
        chk("rst.remaining", 32'(remaining), 32'(AR_TIME - 1));

        rst_n = 1'b0;
        edges = 0;

        // First green after 4 edges; remaining counts 4..0 over the green.
        adv_to(3);  chk_state("pre_green0", 2'd0, 3'd0, L_ALLRED);
        adv_to(4);  chk_state("green0", 2'd1, 3'd0, L_G0);
        chk("green0.rem4", 32'(remaining), 32'd4);
        adv_to(8);  chk("green0.rem3", 32'(remaining), 32'd3);
        adv_to(12); chk("green0.rem2", 32'(remaining), 32'd2);
        adv_to(16); chk("green0.rem1", 32'(remaining), 32'd1);
        adv_to(20); chk("green0.rem0", 32'(remaining), 32'd0);
        adv_to(23); chk_state("green0.end", 2'd1, 3'd0, L_G0);
        adv_to(24); chk_state("yellow0", 2'd2, 3'd0, L_Y0);
        chk("yellow0.rem1", 32'(remaining), 32'd1);
        adv_to(28); chk("yellow0.rem0", 32'(remaining), 32'd0);
        adv_to(31); chk_state("yellow0.end", 2'd2, 3'd0, L_Y0);
        adv_to(32); chk_state("allred1", 2'd0, 3'd1, L_ALLRED);
        chk("allred1.rem", 32'(remaining), 32'd0);
        adv_to(36); chk_state("green1", 2'd1, 3'd1, L_G1);
        adv_to(68); chk_state("green2", 2'd1, 3'd2, L_G2);
        adv_to(96); chk_state("allred0", 2'd0, 3'd0, L_ALLRED);
        adv_to(100); chk_state("green0.cyc2", 2'd1, 3'd0, L_G0);

        // Night mode requested mid-green of way 1: green and yellow run out.
        adv_to(140); night_mode = 1'b1;
        adv_to(151); chk_state("night.green1", 2'd1, 3'd1, L_G1);
        adv_to(152); chk("night.yellow1", 32'(phase), 32'd2);
        adv_to(159); chk("night.yellow1.end", 32'(phase), 32'd2);
        adv_to(160); chk_state("night.allred", 2'd0, 3'd2, L_ALLRED);
        adv_to(164); chk("flash.phase", 32'(phase), 32'd3);
        chk("flash.on", 32'(lights), 32'(L_FLON));
        adv_to(167); chk("flash.on.hold", 32'(lights), 32'(L_FLON));
        adv_to(168); chk("flash.off", 32'(lights), 32'(L_FLOFF));
        adv_to(172); chk("flash.on2", 32'(lights), 32'(L_FLON));

        // Leave night mode: all-red with way 0 at next tick, green a tick later.
        night_mode = 1'b0;
        adv_to(175); chk("flash.hold", 32'(phase), 32'd3);
        adv_to(176); chk_state("flash.exit", 2'd0, 3'd0, L_ALLRED);
        adv_to(180); chk_state("flash.green0", 2'd1, 3'd0, L_G0);

        // Reset pulse during yellow of way 2 (yellow spans edges 264..271).
        adv_to(266); chk_state("yellow2", 2'd2, 3'd2, 9'b010_100_100);
        rst_n = 1'b1;
        #1;
        chk_state("async_rst", 2'd0, 3'd0, L_ALLRED);
        chk("async_rst.rem", 32'(remaining), 32'(AR_TIME - 1));
        @(negedge clk);
        rst_n = 1'b0;
        edges = 0;
        adv_to(3); chk_state("restart.pre", 2'd0, 3'd0, L_ALLRED);
        adv_to(4); chk_state("restart.green0", 2'd1, 3'd0, L_G0);
        adv_to(36); chk_state("restart.green1", 2'd1, 3'd1, L_G1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
